// File: rtl/fill_counter_pkg.sv
// Shared BCD digit definitions for the fill/clean timing counter.
package fill_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    bcd_digit_t r;
    if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with same-cycle carry/borrow ripple in and out.
module bcd_digit_cell
  import fill_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] reset_value,
  input  logic [3:0] load_value,
  input  logic       dir,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] digit
);

  bcd_digit_t digit_r;
  bcd_digit_t next_s;
  logic       cout_s;

  // next digit value and ripple out when this digit is stepped
  always_comb begin
    next_s = digit_r;
    cout_s = 1'b0;
    if (cin) begin
      if (dir) begin
        if (digit_r == 4'd0) begin
          next_s = BCD_MAX;
          cout_s = 1'b1;
        end else begin
          next_s = digit_r - 4'd1;
          cout_s = 1'b0;
        end
      end else begin
        if (digit_r >= BCD_MAX) begin
          next_s = 4'd0;
          cout_s = 1'b1;
        end else begin
          next_s = digit_r + 4'd1;
          cout_s = 1'b0;
        end
      end
    end else begin
      next_s = digit_r;
      cout_s = 1'b0;
    end
  end

  // digit register: reset, then load, then step
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_r <= bcd_clamp(reset_value);
    end else if (load) begin
      digit_r <= bcd_clamp(load_value);
    end else begin
      digit_r <= next_s;
    end
  end

  assign cout  = cout_s;
  assign digit = digit_r;

endmodule

// File: rtl/fill_bcd_counter.sv
// N-digit up/down BCD counter with load, terminal decode and wrap flag.
// Define FILL_BCD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module fill_bcd_counter
  import fill_counter_pkg::*;
#(
  parameter int                    DIGITS = 3,
  parameter logic [4*DIGITS-1:0]   PRESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pulse,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  terminal,
  output logic                  wrap
);

  logic [DIGITS:0] carry_s;
  logic            step_s;
  logic            all_nine_s;
  logic            all_zero_s;
  logic            at_limit_s;
  logic            wrap_event_s;
  logic            wrap_r;

  assign step_s = enable & pulse & ~load;

`ifdef FILL_BCD_COUNTER_SATURATE_EN
  // a step at the limit is swallowed entirely so count never moves
  assign carry_s[0]   = step_s & ~at_limit_s;
  assign wrap_event_s = step_s & at_limit_s;
`else
  assign carry_s[0]   = step_s;
  assign wrap_event_s = carry_s[DIGITS];
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .reset_value (PRESET[4*g +: 4]),
        .load_value  (load_value[4*g +: 4]),
        .dir         (dir),
        .cin         (carry_s[g]),
        .cout        (carry_s[g+1]),
        .digit       (count[4*g +: 4])
      );
    end
  endgenerate

  // all-nines / all-zeros decode of the registered count
  always_comb begin
    all_nine_s = 1'b1;
    all_zero_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != BCD_MAX) begin
        all_nine_s = 1'b0;
      end else begin
        all_nine_s = all_nine_s;
      end
      if (count[4*i +: 4] != 4'd0) begin
        all_zero_s = 1'b0;
      end else begin
        all_zero_s = all_zero_s;
      end
    end
  end

  assign at_limit_s = dir ? all_zero_s : all_nine_s;
  assign terminal   = at_limit_s;

  // single-cycle wrap/blocked-step flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_r <= 1'b0;
    end else if (load) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_event_s;
    end
  end

  assign wrap = wrap_r;

endmodule

// File: tb/tb_fill_bcd_counter.sv
// Directed self-checking bench for fill_bcd_counter (DIGITS=3, PRESET=0x905).
module tb_fill_bcd_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pulse;
  logic        dir;
  logic        load;
  logic [11:0] load_value;
  logic [11:0] count;
  logic        terminal;
  logic        wrap;

  int n_checks;
  int n_fail;

  fill_bcd_counter #(.DIGITS(3), .PRESET(12'h905)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pulse      (pulse),
    .dir        (dir),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .terminal   (terminal),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    enable = 1'b0;
    pulse = 1'b0;
    dir = 1'b0;
    load = 1'b0;
    load_value = 12'h000;

    // reset state
    tick();
    reset = 1'b0;
    check("reset_count", {20'd0, count}, 32'h905);
    check("reset_wrap", {31'd0, wrap}, 32'd0);
    check("reset_term_up", {31'd0, terminal}, 32'd0);
    dir = 1'b1;
    #1;
    check("reset_term_dn", {31'd0, terminal}, 32'd0);
    dir = 1'b0;

    // up with carries
    do_load(12'h098);
    check("load_098", {20'd0, count}, 32'h098);
    enable = 1'b1;
    pulse = 1'b1;
    tick();
    check("up_099", {20'd0, count}, 32'h099);
    tick();
    check("up_100", {20'd0, count}, 32'h100);
    check("up_100_wrap", {31'd0, wrap}, 32'd0);
    tick();
    check("up_101", {20'd0, count}, 32'h101);
    check("up_101_wrap", {31'd0, wrap}, 32'd0);
    pulse = 1'b0;

    // up wrap / saturate at 999
    do_load(12'h999);
    check("term_999_up", {31'd0, terminal}, 32'd1);
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
`ifdef FILL_BCD_COUNTER_SATURATE_EN
    check("up_sat_count", {20'd0, count}, 32'h999);
    check("up_sat_term", {31'd0, terminal}, 32'd1);
`else
    check("up_wrap_count", {20'd0, count}, 32'h000);
`endif
    check("up_wrap_flag", {31'd0, wrap}, 32'd1);
    tick();
    check("up_wrap_clear", {31'd0, wrap}, 32'd0);

    // down with borrows
    dir = 1'b1;
    do_load(12'h100);
    pulse = 1'b1;
    tick();
    check("dn_099", {20'd0, count}, 32'h099);
    tick();
    check("dn_098", {20'd0, count}, 32'h098);
    pulse = 1'b0;

    // down wrap / saturate at 000
    do_load(12'h000);
    check("term_000_dn", {31'd0, terminal}, 32'd1);
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
`ifdef FILL_BCD_COUNTER_SATURATE_EN
    check("dn_sat_count", {20'd0, count}, 32'h000);
`else
    check("dn_wrap_count", {20'd0, count}, 32'h999);
`endif
    check("dn_wrap_flag", {31'd0, wrap}, 32'd1);
    tick();
    check("dn_wrap_clear", {31'd0, wrap}, 32'd0);

    // load clamps and beats a pulse; enable low holds
    dir = 1'b0;
    pulse = 1'b1;
    do_load(12'hFA3);
    check("load_clamp", {20'd0, count}, 32'h993);
    check("load_wrap", {31'd0, wrap}, 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_disabled", {20'd0, count}, 32'h993);
    end
    pulse = 1'b0;

    // terminal follows dir immediately
    do_load(12'h999);
    check("term_dir_up", {31'd0, terminal}, 32'd1);
    dir = 1'b1;
    #1;
    check("term_dir_dn", {31'd0, terminal}, 32'd0);
    dir = 1'b0;

    // reset beats a wrapping step
    enable = 1'b1;
    pulse = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse = 1'b0;
    check("rst_vs_wrap_count", {20'd0, count}, 32'h905);
    check("rst_vs_wrap_flag", {31'd0, wrap}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
